// File: rtl/bsg_wormhole_router_adapter_in_if.sv
// Message-in / flit-out handshake bundle for the wormhole input adapter.
// Latency: none; this is wiring only.
// Backpressure: valid/ready on both sides. The slave is the adapter and the master is its environment.
interface bsg_wormhole_router_adapter_in_if #(
  parameter int msg_width_p  = 541,
  parameter int flit_width_p = 136
) ();
  logic [msg_width_p-1:0]  data_i;
  logic                    v_i;
  logic                    ready_o;
  logic [flit_width_p-1:0] data_o;
  logic                    v_o;
  logic                    ready_i;

  modport slave (
    input  data_i, v_i, ready_i,
    output ready_o, data_o, v_o
  );

  modport master (
    output data_i, v_i, ready_i,
    input  ready_o, data_o, v_o
  );
endinterface

// File: rtl/bsg_wormhole_router_adapter_in.sv
// Splits one wide message into 1..4 wormhole flits. The flit count comes from the len field at [3:2].
// Latency: flit 0 appears one cycle after accept, and a new message can be taken on the last-flit cycle.
// Backpressure: ready_i=0 holds the current flit. ready_o is asserted in IDLE or on a last-flit transfer.
module bsg_wormhole_router_adapter_in #(
  parameter int max_num_flit_p      = 4,
  parameter int max_payload_width_p = 537,
  parameter int x_cord_width_p      = 1,
  parameter int y_cord_width_p      = 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  bsg_wormhole_router_adapter_in_if.slave bus
);

  localparam int len_width_lp  = $clog2(max_num_flit_p);
  localparam int cord_width_lp = x_cord_width_p + y_cord_width_p;
  localparam int msg_width_lp  = cord_width_lp + len_width_lp + max_payload_width_p;
  localparam int flit_width_lp = (msg_width_lp + max_num_flit_p - 1) / max_num_flit_p;
  localparam int pad_width_lp  = flit_width_lp * max_num_flit_p;

  typedef enum logic {e_idle, e_send} state_e;

  state_e                    r_state;
  logic [len_width_lp-1:0]   r_cnt;
  logic [msg_width_lp-1:0]   r_msg;

  logic [pad_width_lp-1:0]   w_msg_pad;
  logic [flit_width_lp-1:0]  w_flits [max_num_flit_p];
  logic                      w_last;
  logic                      w_accept;
  logic                      w_xfer;
  logic                      w_ready;
  logic                      w_valid;

  // Zero-extend the message to a whole number of flits and slice it into flits.
  always_comb begin
    w_msg_pad = '0;
    w_msg_pad[msg_width_lp-1:0] = r_msg;
    for (int k = 0; k < max_num_flit_p; k++) begin
      w_flits[k] = w_msg_pad[k*flit_width_lp +: flit_width_lp];
    end
  end

  // Handshake decode. Reset masks both outputs so that nothing is accepted or sent while it is held.
  always_comb begin
    w_last   = (r_cnt == r_msg[cord_width_lp +: len_width_lp]);
    w_valid  = ~reset_i & (r_state == e_send);
    w_ready  = ~reset_i & ((r_state == e_idle) | ((r_state == e_send) & w_last & bus.ready_i));
    w_accept = bus.v_i & w_ready;
    w_xfer   = w_valid & bus.ready_i;
  end

  assign bus.ready_o = w_ready;
  assign bus.v_o     = w_valid;
  assign bus.data_o  = w_flits[r_cnt];

  // Control FSM. An accept takes priority, so a last-flit transfer with a new accept stays in SEND.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= e_send;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_state <= e_idle;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  // The message buffer is written only on accept. It needs no reset because the FSM gates its use.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_msg <= bus.data_i;
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_in.sv
// Directed and scoreboarded bench for the wormhole input adapter.
// Inputs are driven on the falling edge and outputs are sampled 1ns later.
// The scoreboard rebuilds messages from the flits using the len field.
module tb_bsg_wormhole_router_adapter_in;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  bsg_wormhole_router_adapter_in_if #(.msg_width_p(541), .flit_width_p(136)) u_if ();

  bsg_wormhole_router_adapter_in dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (u_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Build a message with fields {payload, len, y, x} and a seeded payload pattern.
  function automatic logic [540:0] mk(input logic [1:0] len, input logic [1:0] cord, input int seed);
    logic [540:0] m;
    m = '0;
    for (int i = 0; i < 537; i++) m[4+i] = (((i * seed) + i) % 7) < 3;
    m[3:2] = len;
    m[1:0] = cord;
    return m;
  endfunction

  function automatic logic [540:0] rnd_msg();
    logic [543:0] t;
    for (int w = 0; w < 17; w++) t[w*32 +: 32] = $urandom;
    return t[540:0];
  endfunction

  function automatic logic [135:0] flit_of(input logic [540:0] m, input int k);
    logic [543:0] p;
    p = {3'b000, m};
    return p[k*136 +: 136];
  endfunction

  logic [540:0] sb_q [$];
  int           sb_k    = 0;
  int           sb_rcvd = 0;
  int           sb_sent = 0;

  // Check one output flit against the front of the scoreboard queue.
  task automatic sb_rx();
    if (u_if.v_o && u_if.ready_i) begin
      if (sb_q.size() == 0) begin
        chk("sb_spurious", 1, 0);
      end else begin
        chk("sb_flit", u_if.data_o, flit_of(sb_q[0], sb_k));
        if (sb_k == int'(sb_q[0][3:2])) begin
          void'(sb_q.pop_front());
          sb_k = 0;
          sb_rcvd++;
        end else begin
          sb_k++;
        end
      end
    end
  endtask

  logic [540:0] m, a, b, cur;
  int           xfers;
  int           vcnt;
  bit           have;
  int           rp [5] = '{1, 0, 0, 1, 1};
  int           ef [5] = '{0, 1, 1, 1, 2};

  initial begin
    reset_i      = 1'b1;
    u_if.v_i     = 1'b0;
    u_if.ready_i = 1'b0;
    u_if.data_i  = '0;
    tick();
    tick();

    // Reset: v_i is ignored while reset is held.
    u_if.v_i    = 1'b1;
    u_if.data_i = mk(2'd0, 2'b01, 1);
    #1;
    chk("rst_rdy", u_if.ready_o, 0);
    chk("rst_vld", u_if.v_o, 0);
    tick();
    u_if.v_i = 1'b0;
    reset_i  = 1'b0;
    #1;
    chk("post_rst_rdy", u_if.ready_o, 1);
    chk("post_rst_vld", u_if.v_o, 0);
    tick();
    #1;
    chk("rst_no_capture", u_if.v_o, 0);

    // Single flit.
    m = mk(2'd0, 2'b01, 11);
    u_if.data_i  = m;
    u_if.v_i     = 1'b1;
    u_if.ready_i = 1'b1;
    #1;
    chk("single_acc_rdy", u_if.ready_o, 1);
    tick();
    u_if.v_i = 1'b0;
    #1;
    chk("single_vld", u_if.v_o, 1);
    chk("single_dat", u_if.data_o, flit_of(m, 0));
    chk("single_low4", u_if.data_o[3:0], 4'b0001);
    chk("single_rdy", u_if.ready_o, 1);
    tick();
    #1;
    chk("single_done", u_if.v_o, 0);

    // Maximum length: four consecutive flits with a zero pad in flit 3.
    m = mk(2'd3, 2'b10, 5);
    u_if.data_i = m;
    u_if.v_i    = 1'b1;
    tick();
    u_if.v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("max_vld", u_if.v_o, 1);
      chk("max_dat", u_if.data_o, flit_of(m, k));
      if (k == 0) chk("max_low4", u_if.data_o[3:0], 4'b1110);
      if (k == 3) chk("max_pad", u_if.data_o[135:133], 3'b000);
      tick();
    end
    #1;
    chk("max_done", u_if.v_o, 0);

    // Backpressure: flit 1 is held for three cycles.
    m = mk(2'd2, 2'b11, 3);
    u_if.data_i = m;
    u_if.v_i    = 1'b1;
    tick();
    u_if.v_i = 1'b0;
    xfers    = 0;
    for (int c = 0; c < 5; c++) begin
      u_if.ready_i = rp[c][0];
      #1;
      chk("bp_vld", u_if.v_o, 1);
      chk("bp_dat", u_if.data_o, flit_of(m, ef[c]));
      if (u_if.v_o && u_if.ready_i) xfers++;
      tick();
    end
    u_if.ready_i = 1'b1;
    #1;
    chk("bp_done", u_if.v_o, 0);
    chk("bp_xfers", xfers, 3);

    // Back-to-back: message B is accepted in the A1 cycle with no bubble.
    a = mk(2'd1, 2'b00, 2);
    b = mk(2'd0, 2'b11, 9);
    u_if.data_i = a;
    u_if.v_i    = 1'b1;
    tick();
    u_if.data_i = b;
    #1;
    chk("b2b_a0_dat", u_if.data_o, flit_of(a, 0));
    chk("b2b_a0_rdy", u_if.ready_o, 0);
    tick();
    #1;
    chk("b2b_a1_dat", u_if.data_o, flit_of(a, 1));
    chk("b2b_a1_rdy", u_if.ready_o, 1);
    tick();
    u_if.v_i = 1'b0;
    #1;
    chk("b2b_b0_vld", u_if.v_o, 1);
    chk("b2b_b0_dat", u_if.data_o, flit_of(b, 0));
    tick();
    #1;
    chk("b2b_done", u_if.v_o, 0);

    // Reset mid-message discards the remaining flits.
    m = mk(2'd3, 2'b01, 4);
    u_if.data_i = m;
    u_if.v_i    = 1'b1;
    tick();
    u_if.v_i = 1'b0;
    tick();
    tick();
    reset_i     = 1'b1;
    u_if.v_i    = 1'b1;
    u_if.data_i = mk(2'd2, 2'b10, 8);
    #1;
    chk("rmid_vld", u_if.v_o, 0);
    chk("rmid_rdy", u_if.ready_o, 0);
    tick();
    reset_i  = 1'b0;
    u_if.v_i = 1'b0;
    #1;
    chk("rmid_after_vld", u_if.v_o, 0);
    chk("rmid_after_rdy", u_if.ready_o, 1);
    m = mk(2'd0, 2'b01, 6);
    u_if.data_i = m;
    u_if.v_i    = 1'b1;
    tick();
    u_if.v_i = 1'b0;
    #1;
    chk("rmid_new_vld", u_if.v_o, 1);
    chk("rmid_new_dat", u_if.data_o, flit_of(m, 0));
    tick();
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (u_if.v_o) vcnt++;
      tick();
    end
    chk("rmid_no_resend", vcnt, 0);

    // Random stress with the scoreboard.
    have = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!have) begin
        cur  = rnd_msg();
        have = 1'b1;
      end
      u_if.data_i  = cur;
      u_if.v_i     = 1'($urandom_range(0, 1));
      u_if.ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (u_if.v_i && u_if.ready_o) begin
        sb_q.push_back(cur);
        have = 1'b0;
        sb_sent++;
      end
      sb_rx();
      tick();
    end
    u_if.v_i     = 1'b0;
    u_if.ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      sb_rx();
      tick();
    end
    chk("sb_count", sb_rcvd, sb_sent);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
